fft2x2_bfly_ser: RTL and testbench

Downstream consumer of the 2x2 twiddle-multiply stage in the 2D 4-point FFT. It accepts one 2x2 block of complex samples per handshake, which has already been twiddled. It computes the 2D 2-point butterflies in two registered steps: rows, then columns. It then streams the four complex results out one per beat, in index order, under a valid/ready handshake.

---
 rtl/fft2x2_bfly_ser_pkg.sv | 57 +++++
 rtl/fft2x2_bfly_ser_if.sv | 37 +++
 rtl/fft2x2_bfly_ser_cplx_bfly2.sv | 22 ++
 rtl/fft2x2_bfly_ser.sv | 98 +++++++++
 tb/tb_fft2x2_bfly_ser.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft2x2_bfly_ser_pkg.sv
// Shared types, widths and the output scaling helper for the serial 2x2 butterfly stage.
// Build option: FFT_BFLY_SAT_EN selects saturating unit-gain output instead of 1/4 gain.
package fft2x2_bfly_ser_pkg;

  localparam int unsigned DW  = 16;      // input/output component width
  localparam int unsigned S1W = DW + 1;  // row butterfly width
  localparam int unsigned S2W = DW + 2;  // column butterfly width (BflyBus 17:0)

  // FFT stage control states, shared with the upstream stage
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COL  = 2'd1,
    SEND = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } in_bus_t;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } out_bus_t;

  typedef struct packed {
    logic signed [S1W-1:0] re;
    logic signed [S1W-1:0] im;
  } row_bus_t;

  typedef struct packed {
    logic signed [S2W-1:0] re;
    logic signed [S2W-1:0] im;
  } bfly_bus_t;

  // Reduce an 18-bit column result to DW bits
  function automatic logic signed [DW-1:0] scale(input logic signed [S2W-1:0] x);
`ifdef FFT_BFLY_SAT_EN
    logic signed [S2W-1:0] sat_max;
    logic signed [S2W-1:0] sat_min;
    sat_max = S2W'((2 ** (DW - 1)) - 1);
    sat_min = S2W'(-(2 ** (DW - 1)));
    if (x > sat_max) begin
      return DW'(sat_max);
    end else if (x < sat_min) begin
      return DW'(sat_min);
    end else begin
      return DW'(x);
    end
`else
    logic signed [S2W-1:0] sh;
    sh = x >>> 2;  // floors; the 1/4 gain result always fits in DW
    return DW'(sh);
`endif
  endfunction

endpackage

// File: rtl/fft2x2_bfly_ser_if.sv
// Handshake and data bundle of the serial 2x2 butterfly stage.
// slave  : seen by the stage (block input side consumed, result beat side produced).
// master : seen by whoever feeds blocks and drains results.
interface fft2x2_bfly_ser_if;
  import fft2x2_bfly_ser_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_1_1_r;
  logic signed [DW-1:0] in_1_1_i;
  logic signed [DW-1:0] in_1_2_r;
  logic signed [DW-1:0] in_1_2_i;
  logic signed [DW-1:0] in_2_1_r;
  logic signed [DW-1:0] in_2_1_i;
  logic signed [DW-1:0] in_2_2_r;
  logic signed [DW-1:0] in_2_2_i;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_r;
  logic signed [DW-1:0] out_i;
  logic [1:0]           out_idx;
  logic                 out_last;
  logic                 busy;

  modport slave (
    input  in_valid, in_1_1_r, in_1_1_i, in_1_2_r, in_1_2_i,
           in_2_1_r, in_2_1_i, in_2_2_r, in_2_2_i, out_ready,
    output in_ready, out_valid, out_r, out_i, out_idx, out_last, busy
  );

  modport master (
    output in_valid, in_1_1_r, in_1_1_i, in_1_2_r, in_1_2_i,
           in_2_1_r, in_2_1_i, in_2_2_r, in_2_2_i, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_idx, out_last, busy
  );

endinterface

// File: rtl/fft2x2_bfly_ser_cplx_bfly2.sv
// Combinational complex 2-point butterfly: sum = a + b, dif = a - b, one bit of growth.
// Ports: a_r/a_i, b_r/b_i (W bits signed) in; sum_r/sum_i, dif_r/dif_i (W+1 bits signed) out.
module cplx_bfly2 #(
  parameter int unsigned W = 16
) (
  input  logic signed [W-1:0] a_r,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_r,
  input  logic signed [W-1:0] b_i,
  output logic signed [W:0]   sum_r,
  output logic signed [W:0]   sum_i,
  output logic signed [W:0]   dif_r,
  output logic signed [W:0]   dif_i
);

  // Sign-extend before adding so the result is exact
  assign sum_r = (W+1)'(a_r) + (W+1)'(b_r);
  assign sum_i = (W+1)'(a_i) + (W+1)'(b_i);
  assign dif_r = (W+1)'(a_r) - (W+1)'(b_r);
  assign dif_i = (W+1)'(a_i) - (W+1)'(b_i);

endmodule

// File: rtl/fft2x2_bfly_ser.sv
// Serial 2D 2x2 butterfly stage: accepts one twiddled 2x2 complex block, registers row
// butterflies (s1), then column butterflies (s2), then streams X11, X12, X21, X22 out.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries in_valid/in_ready,
// the eight input components, out_valid/out_ready, out_r/out_i, out_idx, out_last, busy.
// Build option: FFT_BFLY_SAT_EN (see package scale()).
module fft2x2_bfly_ser
  import fft2x2_bfly_ser_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  fft2x2_bfly_ser_if.slave    bus
);

  state_e    state_q;
  logic [1:0] idx_q;
  row_bus_t  s1_q [4];
  bfly_bus_t s2_q [4];

  in_bus_t   x     [4];
  row_bus_t  row_c [4];
  bfly_bus_t col_c [4];
  logic      beat_done;

  // Input block in index order x11, x12, x21, x22
  assign x[0] = '{re: bus.in_1_1_r, im: bus.in_1_1_i};
  assign x[1] = '{re: bus.in_1_2_r, im: bus.in_1_2_i};
  assign x[2] = '{re: bus.in_2_1_r, im: bus.in_2_1_i};
  assign x[3] = '{re: bus.in_2_2_r, im: bus.in_2_2_i};

  // Row butterflies: r0/r1 from the first row, r2/r3 from the second
  cplx_bfly2 #(.W(DW)) u_row0 (
    .a_r(x[0].re), .a_i(x[0].im), .b_r(x[1].re), .b_i(x[1].im),
    .sum_r(row_c[0].re), .sum_i(row_c[0].im), .dif_r(row_c[1].re), .dif_i(row_c[1].im)
  );
  cplx_bfly2 #(.W(DW)) u_row1 (
    .a_r(x[2].re), .a_i(x[2].im), .b_r(x[3].re), .b_i(x[3].im),
    .sum_r(row_c[2].re), .sum_i(row_c[2].im), .dif_r(row_c[3].re), .dif_i(row_c[3].im)
  );

  // Column butterflies: X11/X21 from r0,r2 and X12/X22 from r1,r3
  cplx_bfly2 #(.W(S1W)) u_col0 (
    .a_r(s1_q[0].re), .a_i(s1_q[0].im), .b_r(s1_q[2].re), .b_i(s1_q[2].im),
    .sum_r(col_c[0].re), .sum_i(col_c[0].im), .dif_r(col_c[2].re), .dif_i(col_c[2].im)
  );
  cplx_bfly2 #(.W(S1W)) u_col1 (
    .a_r(s1_q[1].re), .a_i(s1_q[1].im), .b_r(s1_q[3].re), .b_i(s1_q[3].im),
    .sum_r(col_c[1].re), .sum_i(col_c[1].im), .dif_r(col_c[3].re), .dif_i(col_c[3].im)
  );

  assign beat_done = (state_q == SEND) && bus.out_ready;

  // Control FSM and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        s1_q[k] <= '0;
        s2_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            for (int k = 0; k < 4; k++) s1_q[k] <= row_c[k];
            state_q <= COL;
          end
        end
        COL: begin
          for (int k = 0; k < 4; k++) s2_q[k] <= col_c[k];
          idx_q   <= 2'd0;
          state_q <= SEND;
        end
        SEND: begin
          if (beat_done) begin
            if (idx_q == 2'd3) begin
              idx_q   <= 2'd0;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Status and beat data decode directly from state, s2 and idx
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_last  = (state_q == SEND) && (idx_q == 2'd3);
  assign bus.out_idx   = idx_q;
  assign bus.out_r     = scale(s2_q[idx_q].re);
  assign bus.out_i     = scale(s2_q[idx_q].im);

endmodule

// File: tb/tb_fft2x2_bfly_ser.sv
module tb_fft2x2_bfly_ser;
  import fft2x2_bfly_ser_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  fft2x2_bfly_ser_if bus();
  fft2x2_bfly_ser dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][15:0] xr;
    logic [3:0][15:0] xi;
    logic [3:0][15:0] er;
    logic [3:0][15:0] ei;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  function automatic int scale_ref(input int v);
`ifdef FFT_BFLY_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    return v >>> 2;
`endif
  endfunction

  // 2D 2-point DFT written out directly
  task automatic model(input int xr[4], input int xi[4], output int er[4], output int ei[4]);
    er[0] = scale_ref(xr[0] + xr[1] + xr[2] + xr[3]);
    er[1] = scale_ref(xr[0] - xr[1] + xr[2] - xr[3]);
    er[2] = scale_ref(xr[0] + xr[1] - xr[2] - xr[3]);
    er[3] = scale_ref(xr[0] - xr[1] - xr[2] + xr[3]);
    ei[0] = scale_ref(xi[0] + xi[1] + xi[2] + xi[3]);
    ei[1] = scale_ref(xi[0] - xi[1] + xi[2] - xi[3]);
    ei[2] = scale_ref(xi[0] + xi[1] - xi[2] - xi[3]);
    ei[3] = scale_ref(xi[0] - xi[1] - xi[2] + xi[3]);
  endtask

  task automatic unpack_vec(input vec_t v, output int xr[4], output int xi[4],
                            output int er[4], output int ei[4]);
    for (int k = 0; k < 4; k++) begin
      xr[k] = int'($signed(v.xr[k]));
      xi[k] = int'($signed(v.xi[k]));
      er[k] = int'($signed(v.er[k]));
      ei[k] = int'($signed(v.ei[k]));
    end
  endtask

  task automatic set_in(input int xr[4], input int xi[4]);
    bus.in_1_1_r = 16'(xr[0]); bus.in_1_1_i = 16'(xi[0]);
    bus.in_1_2_r = 16'(xr[1]); bus.in_1_2_i = 16'(xi[1]);
    bus.in_2_1_r = 16'(xr[2]); bus.in_2_1_i = 16'(xi[2]);
    bus.in_2_2_r = 16'(xr[3]); bus.in_2_2_i = 16'(xi[3]);
  endtask

  // Drain four beats starting in the first SEND cycle; optional stall at beat stall_k
  task automatic collect(input int er[4], input int ei[4], input int stall_k,
                         input int stall_len, input bit hold_valid);
    int k;
    int stalled;
    int cyc;
    k = 0; stalled = 0; cyc = 0;
    while (k < 4 && cyc < 64) begin
      chk($sformatf("beat%0d_valid", k), int'(bus.out_valid), 1);
      chk($sformatf("beat%0d_idx", k), int'(bus.out_idx), k);
      chk($sformatf("beat%0d_r", k), int'(bus.out_r), er[k]);
      chk($sformatf("beat%0d_i", k), int'(bus.out_i), ei[k]);
      chk($sformatf("beat%0d_last", k), int'(bus.out_last), (k == 3) ? 1 : 0);
      if (hold_valid) chk($sformatf("beat%0d_in_ready", k), int'(bus.in_ready), 0);
      if (k == stall_k && stalled < stall_len) begin
        bus.out_ready = 1'b0;
        stalled++;
      end else begin
        bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (bus.out_ready) k++;
      cyc++;
    end
    bus.out_ready = 1'b1;
    if (k < 4) chk("collect_timeout", k, 4);
  endtask

  task automatic run_block(input int xr[4], input int xi[4], input int er[4],
                           input int ei[4], input int stall_k, input int stall_len);
    chk("pre_in_ready", int'(bus.in_ready), 1);
    set_in(xr, xi);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("col_out_valid", int'(bus.out_valid), 0);
    chk("col_busy", int'(bus.busy), 1);
    @(posedge clk); #1;
    collect(er, ei, stall_k, stall_len, 1'b0);
    chk("post_out_valid", int'(bus.out_valid), 0);
    chk("post_in_ready", int'(bus.in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int xr[4], xi[4], er[4], ei[4];
    int ar[4], ai[4], aer[4], aei[4];
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin xr[k] = 0; xi[k] = 0; end
    set_in(xr, xi);

    // Vector table: real block, +full-scale, -full-scale, imaginary impulse
    for (int v = 0; v < 4; v++) vecs[v] = '0;
    vecs[0].xr[0] = 16'd100; vecs[0].xr[1] = 16'd20; vecs[0].xr[2] = 16'd30; vecs[0].xr[3] = 16'd4;
    for (int k = 0; k < 4; k++) begin
      vecs[1].xr[k] = 16'h7FFF;
      vecs[2].xr[k] = 16'h8000;
    end
    vecs[1].er[0] = 16'h7FFF;
    vecs[2].er[0] = 16'h8000;
    vecs[3].xi[0] = 16'd64;
`ifdef FFT_BFLY_SAT_EN
    vecs[0].er[0] = 16'd154; vecs[0].er[1] = 16'd106; vecs[0].er[2] = 16'd86; vecs[0].er[3] = 16'd54;
    for (int k = 0; k < 4; k++) vecs[3].ei[k] = 16'd64;
`else
    vecs[0].er[0] = 16'd38; vecs[0].er[1] = 16'd26; vecs[0].er[2] = 16'd21; vecs[0].er[3] = 16'd13;
    for (int k = 0; k < 4; k++) vecs[3].ei[k] = 16'd16;
`endif

    // Reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_out_idx", int'(bus.out_idx), 0);
    chk("rst_out_r", int'(bus.out_r), 0);
    chk("rst_out_i", int'(bus.out_i), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_busy", int'(bus.busy), 0);
    end

    // Table-driven blocks
    for (int v = 0; v < 4; v++) begin
      unpack_vec(vecs[v], xr, xi, er, ei);
      run_block(xr, xi, er, ei, -1, 0);
    end

    // Backpressure: 3-cycle stall at idx 1
    unpack_vec(vecs[0], xr, xi, er, ei);
    run_block(xr, xi, er, ei, 1, 3);

    // in_valid held high: second block accepted one edge after idx-3 handshake
    unpack_vec(vecs[0], ar, ai, aer, aei);
    unpack_vec(vecs[3], xr, xi, er, ei);
    set_in(ar, ai);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    set_in(xr, xi);
    chk("b2b_col_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    collect(aer, aei, -1, 0, 1'b1);
    chk("b2b_idle_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    chk("b2b_accept_busy", int'(bus.busy), 1);
    chk("b2b_accept_out_valid", int'(bus.out_valid), 0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    collect(er, ei, -1, 0, 1'b0);
    chk("b2b_end_in_ready", int'(bus.in_ready), 1);

    // Reset while sending idx 2
    unpack_vec(vecs[0], xr, xi, er, ei);
    set_in(xr, xi);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_idx", int'(bus.out_idx), 2);
    chk("mid_r", int'(bus.out_r), er[2]);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_out_r", int'(bus.out_r), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_no_beat", int'(bus.out_valid), 0);
    end
    unpack_vec(vecs[1], xr, xi, er, ei);
    run_block(xr, xi, er, ei, -1, 0);

    // Randomized blocks against the reference model
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 4; k++) begin
        xr[k] = int'($signed(16'($urandom)));
        xi[k] = int'($signed(16'($urandom)));
      end
      model(xr, xi, er, ei);
      run_block(xr, xi, er, ei, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
